// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-fetch FSM state encoding.
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);
    logic               req;
    logic [PC_W-1:0]    addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry {instr,pc} holding register for words returning while IF/ID is frozen.
module fetch_skid #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake FSM, skid entry and the IF/ID buffer.
module fetch_stage #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pcenable,
    input  logic               fetchbuffenable,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid
);
    import cpu_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    disc_addr_q, disc_addr_d;
    logic               hold_q, hold_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               req, accept;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    fetch_skid #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept && fetchbuffenable),
        .unload_i (!fetchbuffenable && skid_valid && !branch_taken),
        .clear_i  (branch_taken),
        .instr_i  (imem.rdata),
        .pc_i     (pc_q),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        disc_addr_d  = disc_addr_q;
        hold_d       = 1'b0;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        req          = 1'b0;

        // hold_q keeps req up through a wait even if hazdet stalls meanwhile
        unique case (state_q)
            S_RESET:   req = 1'b0;
            S_FETCH:   req = (!pcenable || hold_q) && !skid_valid;
            S_DISCARD: req = 1'b1;
            default:   req = 1'b0;
        endcase
        accept = (state_q == S_FETCH) && req && imem.ack && !branch_taken;

        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                hold_d = req && !imem.ack && !branch_taken;
                if (branch_taken && req && !imem.ack) begin
                    state_d     = S_DISCARD;
                    disc_addr_d = pc_q;
                end
            end
            S_DISCARD: if (imem.ack) state_d = S_FETCH;
            default:   state_d = S_RESET;
        endcase

        if (branch_taken)
            pc_d = branch_target & ~PC_W'(1);
        else if (accept)
            pc_d = pc_q + PC_W'(2);

        if (branch_taken) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!fetchbuffenable) begin
            if (skid_valid) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr;
                ifid_pc_d    = skid_pc;
            end else if (accept) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem.rdata;
                ifid_pc_d    = pc_q;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            disc_addr_q  <= RESET_PC;
            hold_q       <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            disc_addr_q  <= disc_addr_d;
            hold_q       <= hold_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // a discarded request keeps its original address until its ack drains
    assign imem.req   = req;
    assign imem.addr  = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, waits, skid, branch discard, wrap, reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        pcenable;
    logic        fetchbuffenable;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    int          total = 0;
    int          bad   = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pcenable        (pcenable),
        .fetchbuffenable (fetchbuffenable),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem            (bus),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_valid      (ifid_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; pcenable = 1'b0; fetchbuffenable = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0;
        bus.ack = 1'b0; bus.rdata = 16'h0;
        tick(); tick();
        chk("rst_req",   32'(bus.req),    32'h0);
        chk("rst_addr",  32'(bus.addr),   32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_instr", 32'(ifid_instr), 32'h0);
        chk("rst_pc",    32'(ifid_pc),    32'h0);

        // S_RESET cycle: no request even with pcenable low
        rst = 1'b0; settle();
        chk("sreset_req", 32'(bus.req), 32'h0);
        tick();

        // zero-wait stream 0..E, one word per cycle
        for (int i = 0; i < 8; i++) begin
            bus.ack = 1'b1; bus.rdata = 16'hA000 + 16'(i); settle();
            chk("stream_req",  32'(bus.req),  32'h1);
            chk("stream_addr", 32'(bus.addr), 32'(2 * i));
            tick();
            chk("stream_pc",    32'(ifid_pc),    32'(2 * i));
            chk("stream_valid", 32'(ifid_valid), 32'h1);
            chk("stream_instr", 32'(ifid_instr), 32'hA000 + 32'(i));
        end

        // 3-cycle wait at 0x10
        bus.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wait_req",  32'(bus.req),  32'h1);
            chk("wait_addr", 32'(bus.addr), 32'h10);
            tick();
            chk("wait_bubble", 32'(ifid_valid), 32'h0);
            chk("wait_nop",    32'(ifid_instr), 32'h0);
        end
        bus.ack = 1'b1; bus.rdata = 16'hB000; tick();
        chk("late_pc",    32'(ifid_pc),    32'h10);
        chk("late_instr", 32'(ifid_instr), 32'hB000);
        chk("late_valid", 32'(ifid_valid), 32'h1);

        // skid: request outstanding at 0x12, ack while both stalls asserted
        bus.ack = 1'b0; tick();
        pcenable = 1'b1; fetchbuffenable = 1'b1;
        bus.ack = 1'b1; bus.rdata = 16'hC000; settle();
        chk("skid_req_held", 32'(bus.req), 32'h1);
        tick();
        bus.ack = 1'b0; settle();
        chk("skid_full_req", 32'(bus.req),    32'h0);
        chk("skid_hold_vld", 32'(ifid_valid), 32'h0);
        tick();
        pcenable = 1'b0; fetchbuffenable = 1'b0; settle();
        chk("skid_rel_req", 32'(bus.req), 32'h0);
        tick();
        chk("skid_out_pc",    32'(ifid_pc),    32'h12);
        chk("skid_out_instr", 32'(ifid_instr), 32'hC000);
        chk("skid_out_valid", 32'(ifid_valid), 32'h1);
        bus.ack = 1'b1; bus.rdata = 16'hC001; settle();
        chk("after_skid_addr", 32'(bus.addr), 32'h14);
        tick();
        chk("after_skid_pc", 32'(ifid_pc), 32'h14);

        // branch to 0x41 while 0x16 outstanding
        bus.ack = 1'b0; branch_taken = 1'b1; branch_target = 16'h0041; settle();
        chk("br_req", 32'(bus.req), 32'h1);
        tick();
        branch_taken = 1'b0;
        chk("br_bubble", 32'(ifid_valid), 32'h0);
        settle();
        chk("disc_req",  32'(bus.req),  32'h1);
        chk("disc_addr", 32'(bus.addr), 32'h16);
        tick();
        bus.ack = 1'b1; bus.rdata = 16'hDEAD; tick();
        chk("disc_drop_vld",   32'(ifid_valid), 32'h0);
        chk("disc_drop_instr", 32'(ifid_instr), 32'h0);
        bus.ack = 1'b0; settle();
        chk("br_new_req",  32'(bus.req),  32'h1);
        chk("br_new_addr", 32'(bus.addr), 32'h40);
        bus.ack = 1'b1; bus.rdata = 16'hE000; tick();
        chk("br_new_pc",    32'(ifid_pc),    32'h40);
        chk("br_new_instr", 32'(ifid_instr), 32'hE000);

        // wrap: redirect to 0xFFFE with no request up, then fetch it
        bus.ack = 1'b0; pcenable = 1'b1;
        branch_taken = 1'b1; branch_target = 16'hFFFE; tick();
        branch_taken = 1'b0; pcenable = 1'b0;
        bus.ack = 1'b1; bus.rdata = 16'hF000; settle();
        chk("wrap_addr", 32'(bus.addr), 32'hFFFE);
        tick();
        chk("wrap_pc", 32'(ifid_pc), 32'hFFFE);
        bus.ack = 1'b0; settle();
        chk("wrap_next_addr", 32'(bus.addr), 32'h0);

        // reset in the middle of a wait at 0x2
        bus.ack = 1'b1; bus.rdata = 16'h1111; tick();
        bus.ack = 1'b0; tick();
        chk("mid_wait_addr", 32'(bus.addr), 32'h2);
        rst = 1'b1; tick();
        chk("mrst_req",   32'(bus.req),    32'h0);
        chk("mrst_addr",  32'(bus.addr),   32'h0);
        chk("mrst_valid", 32'(ifid_valid), 32'h0);
        chk("mrst_instr", 32'(ifid_instr), 32'h0);
        chk("mrst_pc",    32'(ifid_pc),    32'h0);
        rst = 1'b0; bus.ack = 1'b1; bus.rdata = 16'h9999; settle();
        chk("stale_req", 32'(bus.req), 32'h0);
        tick();
        chk("stale_valid", 32'(ifid_valid), 32'h0);
        bus.ack = 1'b0; settle();
        chk("post_rst_req",  32'(bus.req),  32'h1);
        chk("post_rst_addr", 32'(bus.addr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
